// File: rtl/pipe_pkg.sv
// Shared widths and field offsets for the ID/EX pipeline stage register.
// The ID/EX control bundle is laid out as {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp}.
package pipe_pkg;

  localparam int unsigned CtrlWDefault = 8;
  localparam int unsigned DataWDefault = 111;
  localparam int unsigned CntWDefault  = 16;

  // Bit 0 is spare.
  localparam int unsigned CtrlRegWrite = 7;
  localparam int unsigned CtrlMemtoReg = 6;
  localparam int unsigned CtrlMemRead  = 5;
  localparam int unsigned CtrlMemWrite = 4;
  localparam int unsigned CtrlAluSrc   = 3;
  localparam int unsigned CtrlAluOpMsb = 2;
  localparam int unsigned CtrlAluOpLsb = 1;

  localparam int unsigned DataRs1ValLsb = 0;
  localparam int unsigned DataRs2ValLsb = 32;
  localparam int unsigned DataImmLsb    = 64;
  localparam int unsigned DataRs1IdLsb  = 96;
  localparam int unsigned DataRs2IdLsb  = 101;
  localparam int unsigned DataRdIdLsb   = 106;
  localparam int unsigned RegIdW        = 5;
  localparam int unsigned WordW         = 32;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle of the pipeline stage register.
// master drives the inputs and consumes the outputs; slave is the stage itself.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, bubble_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, bubble_cnt
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer that catches an entry accepted while the stage output is stalled.
// Flush and reset both empty and zero the entry.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, flush-to-bubble and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_out_free;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_nxt_valid;
  logic [CTRL_W-1:0] w_nxt_ctrl;
  logic [DATA_W-1:0] w_nxt_data;

  assign w_out_free = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic w_skid_push;
  logic w_skid_pop;

  // in_ready depends only on skid state, breaking the combinational path from out_ready.
  assign w_in_ready  = bus.flush | ~w_skid_valid;
  assign w_skid_push = w_accept & ~bus.flush & ~w_out_free;
  assign w_skid_pop  = ~bus.flush & w_out_free & w_skid_valid;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_flush (bus.flush),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );
`else
  assign w_in_ready   = bus.flush | bus.out_ready | ~r_out_valid;
  assign w_skid_valid = 1'b0;
  assign w_skid_ctrl  = '0;
  assign w_skid_data  = '0;
`endif

  // Flush wins over everything; otherwise a free output takes the skid entry first to keep order.
  always_comb begin
    w_nxt_valid = r_out_valid;
    w_nxt_ctrl  = r_out_ctrl;
    w_nxt_data  = r_out_data;
    if (bus.flush) begin
      w_nxt_valid = 1'b0;
      w_nxt_ctrl  = '0;
    end else if (w_out_free) begin
      if (w_skid_valid) begin
        w_nxt_valid = 1'b1;
        w_nxt_ctrl  = w_skid_ctrl;
        w_nxt_data  = w_skid_data;
      end else if (w_accept) begin
        w_nxt_valid = 1'b1;
        w_nxt_ctrl  = bus.in_ctrl;
        w_nxt_data  = bus.in_data;
      end else begin
        w_nxt_valid = 1'b0;
        w_nxt_ctrl  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= '0;
      r_out_data   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_out_valid <= w_nxt_valid;
      r_out_ctrl  <= w_nxt_ctrl;
      r_out_data  <= w_nxt_data;
      if (!w_nxt_valid && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_ctrl   = r_out_ctrl;
  assign bus.out_data   = r_out_data;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps plus random traffic against a queue model.
// Expectations follow PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage_reg;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 111;
  localparam int unsigned NW = 16;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) bus ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(SW)) sbus ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(SW)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: entries held by the stage in arrival order; head is what out_* shows.
  ent_t          q[$];
  logic [DW-1:0] m_data;
  logic [NW-1:0] m_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit fl, input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
    return fl || (q.size() < 2);
`else
    return fl || ordy || (q.size() == 0);
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_cnt  = '0;
  endtask

  task automatic cycle(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit fl, input bit ordy);
    bit   rdy;
    ent_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    rdy = model_ready(fl, ordy);
    check("in_ready", 128'(bus.in_ready), 128'(rdy));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && rdy) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
    if (q.size() > 0) m_data = q[0].d;
    if (q.size() == 0 && m_cnt != '1) m_cnt++;
    #1;
    check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    check("out_ctrl", 128'(bus.out_ctrl), 128'((q.size() > 0) ? q[0].c : '0));
    check("out_data", 128'(bus.out_data), 128'(m_data));
    check("bubble_cnt", 128'(bus.bubble_cnt), 128'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_ctrl"}, 128'(bus.out_ctrl), 128'(0));
    check({tag, "_data"}, 128'(bus.out_data), 128'(0));
    check({tag, "_cnt"}, 128'(bus.bubble_cnt), 128'(0));
  endtask

  initial begin
    logic [127:0] rnd;
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_ctrl    = '0;
    bus.in_data    = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.in_ctrl   = '0;
    sbus.in_data   = '0;
    sbus.flush     = 1'b0;
    sbus.out_ready = 1'b1;
    model_reset();

    // Reset and bubble count
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("cnt_after_5", 128'(bus.bubble_cnt), 128'(5));

    // Streaming
    cycle(1'b1, 8'hA5, DW'(1), 1'b0, 1'b1);
    cycle(1'b1, 8'hA5, DW'(2), 1'b0, 1'b1);
    check("stream_data2", 128'(bus.out_data), 128'(2));

    // Stall with new offers
    cycle(1'b1, 8'h3C, DW'(3), 1'b0, 1'b1);
    cycle(1'b1, 8'h11, DW'(4), 1'b0, 1'b0);
    cycle(1'b1, 8'h22, DW'(5), 1'b0, 1'b0);
    cycle(1'b1, 8'h33, DW'(6), 1'b0, 1'b0);
    check("stall_ctrl", 128'(bus.out_ctrl), 128'(8'h3C));
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush with a valid offer
    cycle(1'b1, 8'h5A, DW'(32'hDEADBEEF), 1'b0, 1'b1);
    cycle(1'b1, 8'h77, DW'(9), 1'b1, 1'b0);
    check("flush_data", 128'(bus.out_data), 128'(32'hDEADBEEF));
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Order through a stall: A, stall, B, release
    cycle(1'b1, 8'hAA, DW'(10), 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, DW'(11), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom % 4) != 0, CW'($urandom), rnd[DW-1:0], ($urandom % 8) == 0,
            ($urandom % 3) != 0);
    end

    // Reset asserted mid-stall
    cycle(1'b1, 8'hC1, DW'(21), 1'b0, 1'b1);
    cycle(1'b1, 8'hC2, DW'(22), 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;

    // Saturation on the narrow counter instance
    repeat (20) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("sat_cnt20", 128'(sbus.bubble_cnt), 128'(15));
    repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("sat_cnt25", 128'(sbus.bubble_cnt), 128'(15));
    check("sat_valid", 128'(sbus.out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
